rx_queue_arbiter: RTL
=====================

# rx_queue_arbiter

Packet-granular round-robin arbiter that merges the AXI4-Stream outputs of NUM_QUEUES receive queues into one AXI4-Stream master toward the datapath. It sits in the core clock domain, downstream of the per-port MAC receive queues. Once a packet is granted, the arbiter holds the grant until that packet's tlast beat is accepted. The output passes through a registered skid stage, so throughput is one beat per cycle with no combinational path from m_tready to any s_tready.

## Interface
Parameters:
- DATA_WIDTH, 64, tdata width in bits; tstrb width is DATA_WIDTH/8.
- NUM_QUEUES, 4, number of input streams; allowed range 2..8.
- QSEL_WIDTH, 3, width of m_tuser and last_grant; must satisfy 2^QSEL_WIDTH ≥ NUM_QUEUES.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  core clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_tdata  in  NUM_QUEUES*DATA_WIDTH  input data; queue i occupies slice i.
- s_tstrb  in  NUM_QUEUES*DATA_WIDTH/8  input byte strobes.
- s_tvalid  in  NUM_QUEUES  per-queue valid.
- s_tlast  in  NUM_QUEUES  per-queue end of packet.
- s_tready  out  NUM_QUEUES  per-queue ready; at most one bit is high at a time.
- m_tdata  out  DATA_WIDTH  merged output data.
- m_tstrb  out  DATA_WIDTH/8  merged output byte strobes.
- m_tvalid  out  1  merged output valid.
- m_tlast  out  1  merged output end of packet.
- m_tuser  out  QSEL_WIDTH  index of the source queue, constant for every beat of a packet.
- m_tready  in  1  downstream ready.
- pkt_cnt  out  NUM_QUEUES*32  per-queue forwarded-packet counters; present only under RX_ARB_PKT_CNT_EN.

## Operation
- The FSM has two states, IDLE and PKT, and resets to IDLE.
- In IDLE:
  - All s_tready bits are 0.
  - If any s_tvalid is set, grant goes to the first valid queue at or after last_grant+1, modulo NUM_QUEUES.
  - The grant is registered, and the FSM moves to PKT.
- In PKT:
  - s_tready[grant] equals the skid stage's input ready. Every other s_tready bit is 0.
  - A beat transfers when s_tvalid[grant] and s_tready[grant] are both high.
  - When the transferred beat has s_tlast set: last_grant is loaded with grant, the FSM returns to IDLE, and pkt_cnt[grant] increments.
- Fairness:
  - The arbiter never switches queues in the middle of a packet.
  - Any continuously requesting queue is granted within NUM_QUEUES arbitrations.
- Stalls:
  - If the granted queue drops tvalid mid-packet, the arbiter waits in PKT indefinitely. There is no timeout.
  - tdata and tstrb pass through unmodified, including the strobe pattern of the final beat.
- Counters: each pkt_cnt entry is 32 bits and wraps from 0xFFFFFFFF to 0.
- Reset asserted mid-packet: the FSM returns to IDLE and the skid stage is emptied, so the partial packet is lost. Upstream queues must also be reset.

## Timing
- Reset values:
  - Outputs: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tstrb=0, m_tuser=0, pkt_cnt=0.
  - Internal: last_grant=NUM_QUEUES-1, so queue 0 wins the first arbitration.
- Latency:
  - 1 cycle from the first s_tvalid in IDLE to s_tready of the granted queue.
  - 1 cycle from an input beat transfer to m_tvalid.
- Inter-packet gap: exactly one IDLE cycle between packets, so sustained throughput is L/(L+1) beats/cycle for an L-beat packet.
- Skid stage:
  - It holds two entries. Input ready is registered and equals "fewer than two entries held".
  - m_tvalid, once asserted, holds with stable data until m_tready is sampled high.
  - Full-rate streaming is sustained while m_tready stays high.
- Simultaneous events: a tlast beat transferring in the same cycle that new s_tvalid bits rise is handled normally; the next arbitration happens in the following IDLE cycle.

## Configuration
- RX_ARB_PKT_CNT_EN defined: the per-queue 32-bit packet counters and the pkt_cnt port exist.
- RX_ARB_PKT_CNT_EN undefined: the counters and the pkt_cnt port are removed; all other behaviour is identical.

## Structure
- Shared package rx_arb_pkg contains:
  - the state enum (IDLE, PKT);
  - the constant CNT_WIDTH=32;
  - the round-robin next-grant function (priority search rotated from last_grant+1).
- One sub-module, axis_skid_buf: the 2-entry registered AXIS slice carrying {tdata, tstrb, tlast, tuser}, instantiated once on the output.

## Test plan
- Reset, then a 3-beat packet on queue 2 with m_tready=1:
  - m_tvalid rises 2 cycles after s_tvalid[2].
  - m_tuser=2 on every beat; tlast on beat 3; pkt_cnt[2]=1.
- All four queues continuously sending 2-beat packets:
  - Output packet order is queues 0,1,2,3,0,…
  - Every packet is followed by exactly one bubble cycle.
- Queue 1 mid-packet with s_tvalid[1] low for 5 cycles while queue 3 is valid:
  - Queue 3 receives no tready until queue 1's tlast beat is accepted.
- m_tready toggled pseudo-randomly on a 64-beat stream:
  - The output beat sequence is identical to the input, with no drops or duplicates.
  - m_tdata is stable whenever m_tvalid=1 and m_tready=0.
- reset_n pulsed low during beat 2 of a 4-beat packet:
  - All outputs return to 0 asynchronously.
  - The next packet, from queue 0, is forwarded cleanly.
- Under RX_ARB_PKT_CNT_EN, with the counter preloaded to 0xFFFFFFFF by force, one more packet on queue 0 -> pkt_cnt[0]=0.

Source files
------------

// File: rtl/rx_arb_pkg.sv
// Shared types, constants and the round-robin selection helper for rx_queue_arbiter.
package rx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_e;

  localparam int CNT_WIDTH  = 32;
  localparam int MAX_QUEUES = 8;

  // Pick the first requesting queue at or after last+1, wrapping modulo nq.
  // Returns last unchanged when nothing requests (caller only uses it when |req).
  function automatic logic [2:0] rr_next(input logic [MAX_QUEUES-1:0] req,
                                         input logic [2:0]            last,
                                         input int                    nq);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_QUEUES; i++) begin
      idx = (int'(last) + i) % nq;
      if (!found && (i <= nq) && req[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered AXI-Stream slice. in_ready is a flop ("fewer than two
// entries held"), so there is no combinational path from out_ready to in_ready.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             rdy_q;
  logic             push, pop;

  assign push = in_valid & rdy_q;
  assign pop  = (cnt_q != 2'd0) & out_ready;

  // Next-state for occupancy and the head/tail entries.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: if (push) begin
        head_d = in_data;
        cnt_d  = 2'd1;
      end
      2'd1: begin
        case ({push, pop})
          2'b11: head_d = in_data;
          2'b10: begin
            tail_d = in_data;
            cnt_d  = 2'd2;
          end
          2'b01: cnt_d = 2'd0;
          default: ;
        endcase
      end
      2'd2: if (pop) begin
        head_d = tail_q;
        cnt_d  = 2'd1;
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // State registers; ready is computed from next occupancy so it never overfills.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: data entries are reset too, because the merged output must read 0 after reset.
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= (cnt_d != 2'd2);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

endmodule

// File: rtl/rx_queue_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES AXI-Stream receive queues.
// Optional per-queue packet counters are built when RX_ARB_PKT_CNT_EN is defined.
module rx_queue_arbiter
  import rx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_QUEUES = 4,
  parameter int QSEL_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_QUEUES*DATA_WIDTH/8-1:0] s_tstrb,
  input  logic [NUM_QUEUES-1:0]            s_tvalid,
  input  logic [NUM_QUEUES-1:0]            s_tlast,
  output logic [NUM_QUEUES-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [DATA_WIDTH/8-1:0]          m_tstrb,
  output logic                             m_tvalid,
  output logic                             m_tlast,
  output logic [QSEL_WIDTH-1:0]            m_tuser,
  input  logic                             m_tready
`ifdef RX_ARB_PKT_CNT_EN
  ,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]  pkt_cnt
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PAY_W  = DATA_WIDTH + STRB_W + 1 + QSEL_WIDTH;

  state_e                state_q, state_d;
  logic [QSEL_WIDTH-1:0] grant_q, grant_d;
  logic [QSEL_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [STRB_W-1:0]     in_strb;
  logic                  in_last;
  logic                  skid_ready;
  logic                  pkt_done;
  logic [PAY_W-1:0]      skid_out;
  logic [MAX_QUEUES-1:0] req;

  assign req = MAX_QUEUES'(s_tvalid);

  // Route the granted queue into the skid stage and give it the skid's ready.
  always_comb begin
    in_valid = 1'b0;
    in_data  = '0;
    in_strb  = '0;
    in_last  = 1'b0;
    s_tready = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if ((state_q == PKT) && (grant_q == QSEL_WIDTH'(q))) begin
        in_valid    = s_tvalid[q];
        in_data     = s_tdata[q*DATA_WIDTH +: DATA_WIDTH];
        in_strb     = s_tstrb[q*STRB_W +: STRB_W];
        in_last     = s_tlast[q];
        s_tready[q] = skid_ready;
      end
    end
  end

  assign pkt_done = in_valid & skid_ready & in_last;

  // Arbitrate in IDLE, hold the grant through PKT until the tlast beat transfers.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (|s_tvalid) begin
        grant_d = QSEL_WIDTH'(rr_next(req, 3'(last_grant_q), NUM_QUEUES));
        state_d = PKT;
      end
      PKT: if (pkt_done) begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and grant registers; last_grant starts at the top queue so queue 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= QSEL_WIDTH'(NUM_QUEUES - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  axis_skid_buf #(.WIDTH(PAY_W)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   ({in_data, in_strb, in_last, grant_q}),
    .in_valid  (in_valid),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

  assign {m_tdata, m_tstrb, m_tlast, m_tuser} = skid_out;

`ifdef RX_ARB_PKT_CNT_EN
  logic [NUM_QUEUES-1:0][CNT_WIDTH-1:0] cnt_q;

  // Per-queue forwarded-packet counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (pkt_done && (grant_q == QSEL_WIDTH'(q))) cnt_q[q] <= cnt_q[q] + CNT_WIDTH'(1);
      end
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule
